uart_word_tx: RTL and testbench

//  Serialises one 32-bit word as 4 UART 8N1 frames on a single TX line.

---
 rtl/uart_word_tx_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_word_tx.sv | 114 +++++++++++
 tb/tb_uart_word_tx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_word_tx_pkg.sv
// rtl/uart_word_tx_pkg.sv - shared UART definitions: states, frame sizes, byte selection
package uart_word_tx_pkg;

   localparam int UART_BITS            = 8;
   localparam int WORD_BYTES           = 4;
   localparam int DEFAULT_CLKS_PER_BIT = 868;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      DONE  = 3'd4
   } uart_state_t;

   // Byte idx of the word in transmission order; msb_first picks the [31:24] end first.
   function automatic logic [7:0] byte_sel(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input bit          msb_first);
      logic [1:0] pos;
      pos = msb_first ? (2'd3 - idx) : idx;
      return word[8*pos +: 8];
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - baud timer: one bit_tick every CLKS_PER_BIT cycles, restartable by clr
module uart_baud_tick
   import uart_word_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic bit_tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   logic [CNT_W-1:0] cnt_q;
   logic             wrap;

   assign wrap     = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
   assign bit_tick = wrap && !clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr || wrap) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - sends one 32-bit word as four back-to-back UART 8N1 frames
module uart_word_tx
   import uart_word_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter bit MSB_BYTE_1ST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_start,
   input  logic [31:0] tx_data,
   output logic        tx,
   output logic        busy,
   output logic        tx_dataready
);

   uart_state_t state_q, state_d;
   logic [31:0] word_q, word_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [7:0]  cur_byte;
   logic        tx_q, tx_d;
   logic        bit_tick;

   // Held clear while idle so the start bit gets a full period from acceptance.
   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q == IDLE),
      .bit_tick(bit_tick)
   );

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      tx_d       = 1'b1;
      cur_byte   = 8'h00;

      case (state_q)
         IDLE: begin
            if (tx_start) begin
               state_d    = START;
               word_d     = tx_data;
               bit_idx_d  = 3'd0;
               byte_idx_d = 2'd0;
            end
         end
         START: begin
            if (bit_tick) begin
               state_d   = DATA;
               bit_idx_d = 3'd0;
            end
         end
         DATA: begin
            if (bit_tick) begin
               if (bit_idx_q == 3'(UART_BITS - 1)) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (bit_tick) begin
               if (byte_idx_q == 2'(WORD_BYTES - 1)) begin
                  state_d = DONE;
               end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  state_d    = START;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Line level is computed from the next state so tx can be a plain register.
      cur_byte = byte_sel(word_d, byte_idx_d, MSB_BYTE_1ST);
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = cur_byte[bit_idx_d];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         word_q     <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         tx_q       <= tx_d;
      end
   end

   assign tx           = tx_q;
   assign busy         = (state_q == START) || (state_q == DATA) || (state_q == STOP);
   assign tx_dataready = (state_q == DONE);

endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - randomized self-checking bench for uart_word_tx against a frame model
module tb_uart_word_tx;

   localparam int CPB      = 4;
   localparam int WORD_CYC = 40 * CPB;

   logic        clk     = 1'b0;
   logic        rst     = 1'b1;
   logic        start_m = 1'b0;
   logic        start_l = 1'b0;
   logic [31:0] tx_data = 32'h0;
   logic        tx_m, busy_m, rdy_m;
   logic        tx_l, busy_l, rdy_l;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   uart_word_tx #(.CLKS_PER_BIT(CPB), .MSB_BYTE_1ST(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .tx_start(start_m), .tx_data(tx_data),
      .tx(tx_m), .busy(busy_m), .tx_dataready(rdy_m)
   );

   uart_word_tx #(.CLKS_PER_BIT(CPB), .MSB_BYTE_1ST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .tx_start(start_l), .tx_data(tx_data),
      .tx(tx_l), .busy(busy_l), .tx_dataready(rdy_l)
   );

   // Line bits in send order: element n is the n-th bit period on the wire.
   function automatic logic [39:0] frame_bits(input logic [31:0] w, input bit msb);
      logic [39:0] s;
      logic [7:0]  b;
      int          sh;
      s = '0;
      for (int j = 0; j < 4; j++) begin
         sh = msb ? (24 - 8 * j) : (8 * j);
         b  = 8'((w >> sh) & 32'hFF);
         s[10*j +: 10] = {1'b1, b, 1'b0};
      end
      return s;
   endfunction

   // Starts a word from an idle negedge, checks every cycle, returns at the idle negedge after DONE.
   task automatic run_word(input logic [31:0] w, input bit msb, input bit inject,
                           input int abort_at, input string tag);
      logic [39:0] s;
      logic        a_tx, a_busy, a_rdy;
      s       = frame_bits(w, msb);
      tx_data = w;
      if (msb) start_m = 1'b1; else start_l = 1'b1;
      @(negedge clk);
      start_m = 1'b0;
      start_l = 1'b0;
      for (int i = 0; i < WORD_CYC; i++) begin
         if (i > 0) @(negedge clk);
         if (i == abort_at) begin
            rst = 1'b1;
            #1;
            a_tx = msb ? tx_m : tx_l; a_busy = msb ? busy_m : busy_l; a_rdy = msb ? rdy_m : rdy_l;
            n_cmp++;
            if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_rdy !== 1'b0) begin
               n_err++;
               $display("FAIL %s async_reset: tx=%b busy=%b rdy=%b, required tx=1 busy=0 rdy=0",
                        tag, a_tx, a_busy, a_rdy);
            end
            return;
         end
         a_tx = msb ? tx_m : tx_l; a_busy = msb ? busy_m : busy_l; a_rdy = msb ? rdy_m : rdy_l;
         n_cmp++;
         if (a_tx !== s[i/CPB] || a_busy !== 1'b1 || a_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL %s cycle %0d: tx=%b busy=%b rdy=%b, required tx=%b busy=1 rdy=0",
                     tag, i + 1, a_tx, a_busy, a_rdy, s[i/CPB]);
         end
         if (inject && i == 20) begin
            tx_data = 32'hFFFF_FFFF;
            if (msb) start_m = 1'b1; else start_l = 1'b1;
         end
         if (inject && i == 21) begin
            start_m = 1'b0;
            start_l = 1'b0;
         end
      end
      @(negedge clk);
      a_tx = msb ? tx_m : tx_l; a_busy = msb ? busy_m : busy_l; a_rdy = msb ? rdy_m : rdy_l;
      n_cmp++;
      if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL %s done_cycle: tx=%b busy=%b rdy=%b, required tx=1 busy=0 rdy=1",
                  tag, a_tx, a_busy, a_rdy);
      end
      if (inject) begin
         tx_data = 32'hFFFF_FFFF;
         if (msb) start_m = 1'b1; else start_l = 1'b1;
      end
      @(negedge clk);
      start_m = 1'b0;
      start_l = 1'b0;
      a_tx = msb ? tx_m : tx_l; a_busy = msb ? busy_m : busy_l; a_rdy = msb ? rdy_m : rdy_l;
      n_cmp++;
      if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_rdy !== 1'b0) begin
         n_err++;
         $display("FAIL %s idle_gap: tx=%b busy=%b rdy=%b, required tx=1 busy=0 rdy=0",
                  tag, a_tx, a_busy, a_rdy);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({tx_m, busy_m, rdy_m, tx_l, busy_l, rdy_l} !== 6'b100_100) begin
         n_err++;
         $display("FAIL reset_values: tx/busy/rdy msb=%b%b%b lsb=%b%b%b, required 100 100",
                  tx_m, busy_m, rdy_m, tx_l, busy_l, rdy_l);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({tx_m, busy_m, rdy_m, tx_l, busy_l, rdy_l} !== 6'b100_100) begin
            n_err++;
            $display("FAIL idle_after_reset cycle %0d: msb=%b%b%b lsb=%b%b%b, required 100 100",
                     i, tx_m, busy_m, rdy_m, tx_l, busy_l, rdy_l);
         end
      end
   endtask

   task automatic test_msb_order;
      run_word(32'hA55A_0F01, 1'b1, 1'b0, -1, "msb_fixed");
      for (int k = 0; k < 2; k++) run_word($urandom, 1'b1, 1'b0, -1, "msb_random");
   endtask

   task automatic test_lsb_order;
      run_word(32'hA55A_0F01, 1'b0, 1'b0, -1, "lsb_fixed");
      for (int k = 0; k < 2; k++) run_word($urandom, 1'b0, 1'b0, -1, "lsb_random");
   endtask

   task automatic test_ignore_start;
      run_word(32'hA55A_0F01, 1'b1, 1'b1, -1, "ignore_start");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_cmp++;
         if (tx_m !== 1'b1 || busy_m !== 1'b0 || rdy_m !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_start_quiet cycle %0d: tx=%b busy=%b rdy=%b, required tx=1 busy=0 rdy=0",
                     i, tx_m, busy_m, rdy_m);
         end
      end
   endtask

   task automatic test_back_to_back;
      run_word(32'h0000_0000, 1'b1, 1'b0, -1, "b2b_w0");
      run_word(32'hFFFF_FFFF, 1'b1, 1'b0, -1, "b2b_w1");
      run_word(32'h0000_001C, 1'b1, 1'b0, -1, "b2b_w2");
      run_word($urandom, 1'b0, 1'b0, -1, "b2b_lsb_a");
      run_word($urandom, 1'b0, 1'b0, -1, "b2b_lsb_b");
   endtask

   task automatic test_reset_mid_word;
      run_word(32'h1234_5678, 1'b1, 1'b0, 2 * 10 * CPB + 1, "abort");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         n_cmp++;
         if (tx_m !== 1'b1 || busy_m !== 1'b0 || rdy_m !== 1'b0) begin
            n_err++;
            $display("FAIL after_abort cycle %0d: tx=%b busy=%b rdy=%b, required tx=1 busy=0 rdy=0",
                     i, tx_m, busy_m, rdy_m);
         end
      end
      run_word(32'hDEAD_BEEF, 1'b1, 1'b0, -1, "after_abort_word");
   endtask

   initial begin
      test_reset();
      test_msb_order();
      test_lsb_order();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_word();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
